// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU datapath bus.
// Holds the bus width, the select-code width, the number of legal
// sources and the 5-bit code assigned to every bus source.
package cpu_bus_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 5;
    localparam int NUM_SRC    = 24;

    localparam logic [SEL_WIDTH-1:0] SEL_R0     = 5'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_R15    = 5'd15;
    localparam logic [SEL_WIDTH-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_WIDTH-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_WIDTH-1:0] SEL_Z_HIGH = 5'd18;
    localparam logic [SEL_WIDTH-1:0] SEL_Z_LOW  = 5'd19;
    localparam logic [SEL_WIDTH-1:0] SEL_PC     = 5'd20;
    localparam logic [SEL_WIDTH-1:0] SEL_MDR    = 5'd21;
    localparam logic [SEL_WIDTH-1:0] SEL_INPORT = 5'd22;
    localparam logic [SEL_WIDTH-1:0] SEL_C      = 5'd23;

endpackage

// File: rtl/sel_decode_5_32.sv
// One-hot decoder for the bus select code.
// Ports:
//   select   in  5   source code from the bus encoder
//   oneHot   out 24  one bit per legal source, at most one bit set
//   illegal  out 1   select is outside the legal range (24..31)
module sel_decode_5_32
    import cpu_bus_pkg::*;
(
    input  logic [SEL_WIDTH-1:0] select,
    output logic [NUM_SRC-1:0]   oneHot,
    output logic                 illegal
);

    always_comb begin
        oneHot  = '0;
        illegal = 1'b0;
        case (select) inside
            [SEL_R0:SEL_C]: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    oneHot[i] = (select == SEL_WIDTH'(i));
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mux_32_1.sv
// Datapath bus multiplexer: drives the shared CPU bus from one of 24 sources
// selected by a 5-bit code. Illegal codes drive zero and set a sticky flag.
// Build option: define MUX_OUT_REG_EN to register BusMuxOut (1-cycle latency,
// cleared asynchronously); otherwise BusMuxOut is purely combinational.
// Ports:
//   clock, clear                 rising-edge clock, async active-high reset
//   BusMuxIn_* / C_sign_extended 32-bit sources (codes 0..23)
//   select                       5-bit source code
//   BusMuxOut                    selected bus value
//   sel_err                      sticky illegal-select flag
module mux_32_1
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = cpu_bus_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R0,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R1,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R2,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R3,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R4,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R5,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R6,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R7,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R8,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R9,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R10,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R11,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R12,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R13,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R14,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_R15,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_HI,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_LO,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_Z_high,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_Z_low,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_PC,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
    input  logic [DATA_WIDTH-1:0] BusMuxIn_InPort,
    input  logic [DATA_WIDTH-1:0] C_sign_extended,
    input  logic [SEL_WIDTH-1:0]  select,
    output logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic                  sel_err
);

    logic [NUM_SRC-1:0]    oneHot;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] srcArr [NUM_SRC];
    logic [DATA_WIDTH-1:0] muxComb;

    sel_decode_5_32 uDecode (
        .select  (select),
        .oneHot  (oneHot),
        .illegal (illegal)
    );

    // Array index equals the select code.
    assign srcArr[0]  = BusMuxIn_R0;
    assign srcArr[1]  = BusMuxIn_R1;
    assign srcArr[2]  = BusMuxIn_R2;
    assign srcArr[3]  = BusMuxIn_R3;
    assign srcArr[4]  = BusMuxIn_R4;
    assign srcArr[5]  = BusMuxIn_R5;
    assign srcArr[6]  = BusMuxIn_R6;
    assign srcArr[7]  = BusMuxIn_R7;
    assign srcArr[8]  = BusMuxIn_R8;
    assign srcArr[9]  = BusMuxIn_R9;
    assign srcArr[10] = BusMuxIn_R10;
    assign srcArr[11] = BusMuxIn_R11;
    assign srcArr[12] = BusMuxIn_R12;
    assign srcArr[13] = BusMuxIn_R13;
    assign srcArr[14] = BusMuxIn_R14;
    assign srcArr[15] = BusMuxIn_R15;
    assign srcArr[16] = BusMuxIn_HI;
    assign srcArr[17] = BusMuxIn_LO;
    assign srcArr[18] = BusMuxIn_Z_high;
    assign srcArr[19] = BusMuxIn_Z_low;
    assign srcArr[20] = BusMuxIn_PC;
    assign srcArr[21] = BusMuxIn_MDR;
    assign srcArr[22] = BusMuxIn_InPort;
    assign srcArr[23] = C_sign_extended;

    // AND-OR selector: an all-zero one-hot (illegal code) yields zero.
    always_comb begin
        muxComb = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            muxComb = muxComb | (srcArr[i] & {DATA_WIDTH{oneHot[i]}});
        end
    end

`ifdef MUX_OUT_REG_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            BusMuxOut <= '0;
        end else begin
            BusMuxOut <= muxComb;
        end
    end
`else
    assign BusMuxOut = muxComb;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sel_err <= 1'b0;
        end else if (illegal) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_32_1.sv
module tb_mux_32_1;
    import cpu_bus_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] r [16];
    logic [31:0] hi, lo, zHigh, zLow, pc, mdr, inPort, cExt;
    logic [4:0]  select;
    logic [31:0] busMuxOut;
    logic        selErr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expTab [24];

    always #5 clock = ~clock;

    mux_32_1 dut (
        .clock           (clock),
        .clear           (clear),
        .BusMuxIn_R0     (r[0]),
        .BusMuxIn_R1     (r[1]),
        .BusMuxIn_R2     (r[2]),
        .BusMuxIn_R3     (r[3]),
        .BusMuxIn_R4     (r[4]),
        .BusMuxIn_R5     (r[5]),
        .BusMuxIn_R6     (r[6]),
        .BusMuxIn_R7     (r[7]),
        .BusMuxIn_R8     (r[8]),
        .BusMuxIn_R9     (r[9]),
        .BusMuxIn_R10    (r[10]),
        .BusMuxIn_R11    (r[11]),
        .BusMuxIn_R12    (r[12]),
        .BusMuxIn_R13    (r[13]),
        .BusMuxIn_R14    (r[14]),
        .BusMuxIn_R15    (r[15]),
        .BusMuxIn_HI     (hi),
        .BusMuxIn_LO     (lo),
        .BusMuxIn_Z_high (zHigh),
        .BusMuxIn_Z_low  (zLow),
        .BusMuxIn_PC     (pc),
        .BusMuxIn_MDR    (mdr),
        .BusMuxIn_InPort (inPort),
        .C_sign_extended (cExt),
        .select          (select),
        .BusMuxOut       (busMuxOut),
        .sel_err         (selErr)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    initial begin
        expTab = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                   32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                   32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
                   32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF,
                   32'h12345678, 32'h87654321, 32'hABCDEF01, 32'h10FEDCBA,
                   32'hCAFEBABE, 32'hDEADBEEF, 32'h13572468, 32'h24681357};
        for (int i = 0; i < 16; i++) r[i] = expTab[i];
        hi = 32'h12345678;  lo = 32'h87654321;
        zHigh = 32'hABCDEF01; zLow = 32'h10FEDCBA;
        pc = 32'hCAFEBABE;  mdr = 32'hDEADBEEF;
        inPort = 32'h13572468; cExt = 32'h24681357;
        select = 5'd0;
        clear = 1'b1;

        // reset state
        repeat (2) @(posedge clock);
        #1 checkValue("reset_sel_err", {31'b0, selErr}, 32'h0);
        @(negedge clock);
        clear = 1'b0;

        // legal sweep, one code per 10 ns
        for (int s = 0; s < 24; s++) begin
            @(negedge clock);
            select = 5'(s);
            #1 checkValue($sformatf("sweep_sel%0d", s), busMuxOut, expTab[s]);
        end
        @(posedge clock);
        #1 checkValue("legal_no_err", {31'b0, selErr}, 32'h0);

        // illegal codes: zero output, flag after next rising edge
        for (int s = 24; s < 32; s++) begin
            @(negedge clock);
            select = 5'(s);
            #1 checkValue($sformatf("illegal_out%0d", s), busMuxOut, 32'h0);
            if (s == 24) checkValue("err_before_edge", {31'b0, selErr}, 32'h0);
            @(posedge clock);
            #1 checkValue($sformatf("illegal_err%0d", s), {31'b0, selErr}, 32'h1);
        end

        // async clear mid-cycle, then legal select keeps flag low
        @(negedge clock);
        select = 5'd3;
        #2 clear = 1'b1;
        #1 checkValue("clear_async", {31'b0, selErr}, 32'h0);
        checkValue("clear_out_kept", busMuxOut, 32'h33333333);
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1 checkValue("clear_stays", {31'b0, selErr}, 32'h0);

        // clear wins against an illegal select at the same edge
        @(negedge clock);
        select = 5'd31;
        clear = 1'b1;
        @(posedge clock);
        #1 checkValue("clear_wins", {31'b0, selErr}, 32'h0);
        @(negedge clock);
        select = 5'd7;
        clear = 1'b0;
        @(posedge clock);
        #1 checkValue("after_clear_legal", {31'b0, selErr}, 32'h0);

        // source changes while selected
        @(negedge clock);
        select = 5'd20;
        #1 checkValue("pc_before", busMuxOut, 32'hCAFEBABE);
        pc = 32'h0000FFFF;
        #1 checkValue("pc_follow", busMuxOut, 32'h0000FFFF);

        // toggle between 0 and 15 each cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            select = (k % 2 == 0) ? 5'd0 : 5'd15;
            #1 checkValue($sformatf("toggle%0d", k), busMuxOut,
                          (k % 2 == 0) ? 32'h00000000 : 32'hFFFFFFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
